serial_deserializer: RTL and testbench

Serial-to-parallel receiver: the counterpart of the team's parallel-load shift-register transmitter. It samples one serial bit per enabled clock, assembles N-bit words (LSB-first by default, matching the transmitter's right-shift order), and presents each completed word on a one-entry valid/ready output buffer. A sticky overrun flag reports when a completed word overwrites one that was never consumed. It sits at the receive end of the team's serial links, feeding parallel consumers.

---
 rtl/serial_deserializer_pkg.sv | 9 +
 rtl/serial_deserializer_sipo_shift_core.sv | 51 +++++
 rtl/serial_deserializer.sv | 85 ++++++++
 tb/tb_serial_deserializer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/serial_deserializer_pkg.sv
// Shared types for the serial receive path.
package serial_deserializer_pkg;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/serial_deserializer_sipo_shift_core.sv
// Serial-in shift register with bit counter; flags the edge that completes a word
// and exposes the post-shift word so the caller can capture it on that same edge.
module sipo_shift_core #(
  parameter int N         = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sin,
  input  logic         sin_en,
  input  logic         sync,
  output logic         word_done,
  output logic [N-1:0] word,
  output logic         busy
);

  localparam int               CNT_W    = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic [N-1:0]     sh;
  logic [N-1:0]     sh_next;
  logic [CNT_W-1:0] cnt;
  logic             shift;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign sh_next = {sh[N-2:0], sin};
    end else begin : g_lsb
      assign sh_next = {sin, sh[N-1:1]};
    end
  endgenerate

  // sync outranks a coincident strobe: the bit is dropped, not shifted
  assign shift     = sin_en & ~sync;
  assign word_done = shift & (cnt == CNT_LAST);
  assign word      = sh_next;
  assign busy      = (cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh  <= '0;
      cnt <= '0;
    end else if (sync) begin
      cnt <= '0;
    end else if (sin_en) begin
      sh  <= sh_next;
      cnt <= word_done ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: shift core feeding a one-entry valid/ready buffer
// with a sticky overrun flag for words overwritten before being consumed.
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int N         = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sin,
  input  logic         sin_en,
  input  logic         sync,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         overrun,
  input  logic         ovr_clr,
  output logic         busy
);

  logic         word_done;
  logic [N-1:0] word;

  buf_state_e state, state_next;
  logic       load;
  logic       set_ovr;

  sipo_shift_core #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .sin       (sin),
    .sin_en    (sin_en),
    .sync      (sync),
    .word_done (word_done),
    .word      (word),
    .busy      (busy)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= BUF_EMPTY;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    set_ovr    = 1'b0;
    case (state)
      BUF_EMPTY: begin
        if (word_done) begin
          load       = 1'b1;
          state_next = BUF_FULL;
        end
      end
      BUF_FULL: begin
        // newest word always wins; it only counts as lost if nobody took the old one
        if (word_done) begin
          load    = 1'b1;
          set_ovr = ~dout_ready;
        end else if (dout_ready) begin
          state_next = BUF_EMPTY;
        end
      end
      default: state_next = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout    <= '0;
      overrun <= 1'b0;
    end else begin
      if (load) dout <= word;
      if (set_ovr)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  assign dout_valid = (state == BUF_FULL);

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: LSB-first instance for most scenarios,
// a second MSB-first instance for bit-order and strobe-gap checks.
module tb_serial_deserializer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sin, sin_en, sync, dout_ready, ovr_clr;
  logic [3:0] dout;
  logic       dout_valid, overrun, busy;

  logic       m_sin, m_sin_en;
  logic [3:0] m_dout;
  logic       m_dout_valid, m_overrun, m_busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_deserializer #(.N(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .sin(sin), .sin_en(sin_en), .sync(sync),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .overrun(overrun), .ovr_clr(ovr_clr), .busy(busy)
  );

  serial_deserializer #(.N(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset_n(reset_n), .sin(m_sin), .sin_en(m_sin_en), .sync(1'b0),
    .dout(m_dout), .dout_valid(m_dout_valid), .dout_ready(1'b1),
    .overrun(m_overrun), .ovr_clr(1'b0), .busy(m_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // all drivers change at posedge+1 and leave the bench at posedge+1
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin    = b;
    sin_en = 1'b1;
    tick();
    sin_en = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) send_bit(w[i]);
  endtask

  task automatic m_send_bit(input logic b);
    m_sin    = b;
    m_sin_en = 1'b1;
    tick();
    m_sin_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; sin = 1'b0; sin_en = 1'b0; sync = 1'b0;
    dout_ready = 1'b0; ovr_clr = 1'b0; m_sin = 1'b0; m_sin_en = 1'b0;
    tick();
    chk("rst_dout", dout, 4'h0);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    tick();

    // basic LSB-first: 1,1,0,1 -> B
    dout_ready = 1'b1;
    send_bit(1'b1); chk("lsb_busy1", busy, 1'b1);
    send_bit(1'b1); chk("lsb_busy2", busy, 1'b1);
    send_bit(1'b0); chk("lsb_busy3", busy, 1'b1);
    chk("lsb_valid_pre", dout_valid, 1'b0);
    send_bit(1'b1);
    chk("lsb_busy4", busy, 1'b0);
    chk("lsb_dout", dout, 4'hB);
    chk("lsb_valid", dout_valid, 1'b1);
    tick();
    chk("lsb_valid_drop", dout_valid, 1'b0);

    // MSB-first with 3-cycle strobe gaps: 1,0,1,1 -> B
    m_send_bit(1'b1);
    repeat (3) tick();
    chk("msb_gap_busy", m_busy, 1'b1);
    m_send_bit(1'b0);
    repeat (3) tick();
    m_send_bit(1'b1);
    repeat (3) tick();
    chk("msb_gap_valid", m_dout_valid, 1'b0);
    chk("msb_gap_dout", m_dout, 4'h0);
    m_send_bit(1'b1);
    chk("msb_dout", m_dout, 4'hB);
    chk("msb_valid", m_dout_valid, 1'b1);
    chk("msb_busy", m_busy, 1'b0);

    // backpressure: 5 then A unconsumed
    dout_ready = 1'b0;
    send_word(4'h5);
    chk("bp_dout5", dout, 4'h5);
    chk("bp_ovr0", overrun, 1'b0);
    send_word(4'hA);
    chk("bp_doutA", dout, 4'hA);
    chk("bp_valid", dout_valid, 1'b1);
    chk("bp_ovr1", overrun, 1'b1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    chk("bp_clr", overrun, 1'b0);
    chk("bp_clr_dout", dout, 4'hA);
    chk("bp_clr_valid", dout_valid, 1'b1);
    dout_ready = 1'b1; tick(); dout_ready = 1'b0;
    chk("bp_drain", dout_valid, 1'b0);

    // completion coincident with consume: no overrun
    send_word(4'h3);
    chk("sim_dout3", dout, 4'h3);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    chk("sim_hold3", dout, 4'h3);
    dout_ready = 1'b1; send_bit(1'b1); dout_ready = 1'b0;
    chk("sim_doutC", dout, 4'hC);
    chk("sim_valid", dout_valid, 1'b1);
    chk("sim_ovr", overrun, 1'b0);
    // set and clear together: set wins
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    ovr_clr = 1'b1; send_bit(1'b1); ovr_clr = 1'b0;
    chk("sim_dout9", dout, 4'h9);
    chk("sim_set_wins", overrun, 1'b1);
    ovr_clr = 1'b1; dout_ready = 1'b1; tick();
    ovr_clr = 1'b0;
    chk("sim_ovr_clr", overrun, 1'b0);
    chk("sim_drain", dout_valid, 1'b0);

    // sync mid-word drops partial word and the coincident bit
    send_bit(1'b1); send_bit(1'b1);
    chk("sync_pre_busy", busy, 1'b1);
    sync = 1'b1; send_bit(1'b1); sync = 1'b0;
    chk("sync_busy", busy, 1'b0);
    chk("sync_valid", dout_valid, 1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("sync_valid_pre", dout_valid, 1'b0);
    send_bit(1'b0);
    chk("sync_dout", dout, 4'h6);
    chk("sync_valid_post", dout_valid, 1'b1);

    // async reset while FULL with overrun and a partial word
    dout_ready = 1'b0;
    send_word(4'h5);
    send_word(4'hA);
    send_bit(1'b1); send_bit(1'b0);
    chk("ar_pre_ovr", overrun, 1'b1);
    chk("ar_pre_busy", busy, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("ar_dout", dout, 4'h0);
    chk("ar_valid", dout_valid, 1'b0);
    chk("ar_ovr", overrun, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_m_dout", m_dout, 4'h0);
    #2 reset_n = 1'b1;
    tick();
    dout_ready = 1'b1;
    send_word(4'hE);
    chk("ar_next_dout", dout, 4'hE);
    chk("ar_next_valid", dout_valid, 1'b1);
    chk("ar_next_ovr", overrun, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
